// File: rtl/pinaipple_pkg.sv
// System address map and response-order tags shared by the Ibex data bridge.
package pinaipple_pkg;

  localparam logic [31:0] RAM_START   = 32'h0010_0000;
  localparam logic [31:0] RAM_SIZE    = 32'h0001_0000;
  localparam logic [31:0] RAM_MASK    = ~(RAM_SIZE - 32'd1);

  localparam logic [31:0] GPIO_START  = 32'h8000_0000;
  localparam logic [31:0] GPIO_SIZE   = 32'h0000_1000;
  localparam logic [31:0] GPIO_MASK   = ~(GPIO_SIZE - 32'd1);

  localparam logic [31:0] UART_START  = 32'h8000_1000;
  localparam logic [31:0] UART_SIZE   = 32'h0000_1000;
  localparam logic [31:0] UART_MASK   = ~(UART_SIZE - 32'd1);

  localparam logic [31:0] TIMER_START = 32'h8000_2000;
  localparam logic [31:0] TIMER_SIZE  = 32'h0000_1000;
  localparam logic [31:0] TIMER_MASK  = ~(TIMER_SIZE - 32'd1);

  typedef enum logic {
    TagNet = 1'b0,
    TagErr = 1'b1
  } resp_tag_e;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] start,
                                    input logic [31:0] mask);
    return (addr & mask) == start;
  endfunction

  function automatic logic addr_mapped(input logic [31:0] addr);
    return addr_hit(addr, RAM_START,   RAM_MASK)  |
           addr_hit(addr, GPIO_START,  GPIO_MASK) |
           addr_hit(addr, UART_START,  UART_MASK) |
           addr_hit(addr, TIMER_START, TIMER_MASK);
  endfunction

endpackage

// File: rtl/resp_order_fifo.sv
// Small FIFO of 1-bit response tags; pointers carry one extra wrap bit so
// full and empty are told apart by the MSB.
module resp_order_fifo #(
  parameter int Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic push_data_i,
  input  logic pop_i,
  output logic empty_o,
  output logic full_o,
  output logic head_o
);

  localparam int PW = $clog2(Depth) + 1;
  localparam int IW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_mem [Depth];
  logic [IW-1:0] w_widx;
  logic [IW-1:0] w_ridx;
  logic          w_push;
  logic          w_pop;

  // Depth is a power of two, so the modulo is just a bit select
  assign w_widx  = IW'(r_wptr % PW'(Depth));
  assign w_ridx  = IW'(r_rptr % PW'(Depth));
  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = ((r_wptr ^ r_rptr) == PW'(Depth));
  assign head_o  = r_mem[w_ridx];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[w_widx] <= push_data_i;
  end

endmodule

// File: rtl/ibex_data_bridge.sv
// Ibex req/gnt/rvalid data port to valid/ready interconnect host port, with
// address decode and in-order local error responses for unmapped accesses.
module ibex_data_bridge
  import pinaipple_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [DataWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   net_req_valid_o,
  input  logic                   net_req_ready_i,
  output logic [DataWidth-1:0]   net_tgt_addr_o,
  output logic                   net_wen_o,
  output logic [DataWidth/8-1:0] net_be_o,
  output logic [DataWidth-1:0]   net_wdata_o,
  input  logic                   net_resp_valid_i,
  output logic                   net_resp_ready_o,
  input  logic [DataWidth-1:0]   net_resp_rdata_i
);

  localparam int CW = $clog2(MaxOutstanding + 1);

  logic [CW-1:0] r_count;
  logic          w_mapped;
  logic          w_full;
  logic          w_gnt;
  logic          w_pop;
  logic          w_empty;
  logic          w_fifo_full;
  logic          w_head;
  logic          w_head_net;
  logic          w_head_err;
  resp_tag_e     w_push_tag;

  assign w_mapped   = addr_mapped(32'(data_addr_i));
  assign w_full     = (r_count == CW'(MaxOutstanding));
  assign w_gnt      = rst_ni & data_req_i & ~w_full & (~w_mapped | net_req_ready_i);
  assign w_push_tag = w_mapped ? TagNet : TagErr;

  // Outputs are forced low while reset is asserted, including pass-throughs
  assign data_gnt_o      = w_gnt;
  assign net_req_valid_o = rst_ni & data_req_i & w_mapped & ~w_full;
  assign net_tgt_addr_o  = rst_ni ? data_addr_i  : '0;
  assign net_wen_o       = rst_ni & data_we_i;
  assign net_be_o        = rst_ni ? data_be_i    : '0;
  assign net_wdata_o     = rst_ni ? data_wdata_i : '0;

  assign w_head_net = ~w_empty & (resp_tag_e'(w_head) == TagNet);
  assign w_head_err = ~w_empty & (resp_tag_e'(w_head) == TagErr);

  assign net_resp_ready_o = w_head_net;
  assign data_rvalid_o    = w_head_err | (w_head_net & net_resp_valid_i);
  assign data_err_o       = w_head_err;
  assign data_rdata_o     = w_head_net ? net_resp_rdata_i : '0;
  assign w_pop            = data_rvalid_o;

  resp_order_fifo #(
    .Depth (MaxOutstanding)
  ) u_order_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_gnt),
    .push_data_i (logic'(w_push_tag)),
    .pop_i       (w_pop),
    .empty_o     (w_empty),
    .full_o      (w_fifo_full),
    .head_o      (w_head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (w_gnt && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_gnt && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  a_resp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_empty |-> !net_resp_valid_i);

  a_count_matches_fifo: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_fifo_full == w_full);

endmodule

// File: tb/tb_ibex_data_bridge.sv
// Directed bench for ibex_data_bridge with an in-order response scoreboard.
module tb_ibex_data_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'hF;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        net_req_valid_o;
  logic        net_req_ready_i = 1'b0;
  logic [31:0] net_tgt_addr_o;
  logic        net_wen_o;
  logic [3:0]  net_be_o;
  logic [31:0] net_wdata_o;
  logic        net_resp_valid_i = 1'b0;
  logic        net_resp_ready_o;
  logic [31:0] net_resp_rdata_i = '0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ibex_data_bridge #(.DataWidth(32), .MaxOutstanding(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .data_req_i       (data_req_i),
    .data_gnt_o       (data_gnt_o),
    .data_rvalid_o    (data_rvalid_o),
    .data_we_i        (data_we_i),
    .data_be_i        (data_be_i),
    .data_addr_i      (data_addr_i),
    .data_wdata_i     (data_wdata_i),
    .data_rdata_o     (data_rdata_o),
    .data_err_o       (data_err_o),
    .net_req_valid_o  (net_req_valid_o),
    .net_req_ready_i  (net_req_ready_i),
    .net_tgt_addr_o   (net_tgt_addr_o),
    .net_wen_o        (net_wen_o),
    .net_be_o         (net_be_o),
    .net_wdata_o      (net_wdata_o),
    .net_resp_valid_i (net_resp_valid_i),
    .net_resp_ready_o (net_resp_ready_o),
    .net_resp_rdata_i (net_resp_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic to_next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wdata;
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (data_rvalid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response at %0t",
                 data_rdata_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_err", {31'd0, data_err_o}, {31'd0, e.err});
        check("rsp_rdata", data_rdata_o, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state: request pending but every output held low
    drive(1'b1, 32'h0010_0004, 4'hF, 32'hA5A5_A5A5);
    to_neg();
    check("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
    check("rst_req_valid", {31'd0, net_req_valid_o}, 32'd0);
    check("rst_tgt_addr", net_tgt_addr_o, 32'd0);
    check("rst_wdata", net_wdata_o, 32'd0);
    check("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    check("rst_resp_ready", {31'd0, net_resp_ready_o}, 32'd0);
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    to_next();
    rst_ni = 1'b1;
    to_next();

    // Test 1: mapped read, response two cycles after grant
    net_req_ready_i = 1'b1;
    drive(1'b0, 32'h0010_0004, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
    to_neg();
    check("t1_gnt", {31'd0, data_gnt_o}, 32'd1);
    check("t1_req_valid", {31'd0, net_req_valid_o}, 32'd1);
    check("t1_tgt_addr", net_tgt_addr_o, 32'h0010_0004);
    to_next();
    data_req_i = 1'b0;
    to_neg();
    check("t1_no_rvalid_c1", {31'd0, data_rvalid_o}, 32'd0);
    check("t1_resp_ready", {31'd0, net_resp_ready_o}, 32'd1);
    to_next();
    net_resp_valid_i = 1'b1;
    net_resp_rdata_i = 32'hDEAD_BEEF;
    to_neg();
    check("t1_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    to_next();
    net_resp_valid_i = 1'b0;

    // Test 2: write held off by interconnect for three cycles
    net_req_ready_i = 1'b0;
    drive(1'b1, 32'h8000_0000, 4'b0011, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("t2_gnt_wait", {31'd0, data_gnt_o}, 32'd0);
      check("t2_req_valid", {31'd0, net_req_valid_o}, 32'd1);
      check("t2_wen", {31'd0, net_wen_o}, 32'd1);
      check("t2_be", {28'd0, net_be_o}, 32'h3);
      to_next();
    end
    net_req_ready_i = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 32'h0});
    to_neg();
    check("t2_gnt", {31'd0, data_gnt_o}, 32'd1);
    check("t2_be_gnt", {28'd0, net_be_o}, 32'h3);
    check("t2_wdata", net_wdata_o, 32'h1234_5678);
    to_next();
    data_req_i       = 1'b0;
    data_we_i        = 1'b0;
    net_resp_valid_i = 1'b1;
    net_resp_rdata_i = 32'h0;
    to_neg();
    to_next();
    net_resp_valid_i = 1'b0;

    // Test 3: unmapped read is granted locally regardless of ready
    net_req_ready_i = 1'b0;
    drive(1'b0, 32'h4000_0000, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    to_neg();
    check("t3_gnt", {31'd0, data_gnt_o}, 32'd1);
    check("t3_req_valid", {31'd0, net_req_valid_o}, 32'd0);
    to_next();
    data_req_i = 1'b0;
    to_neg();
    check("t3_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    check("t3_resp_ready", {31'd0, net_resp_ready_o}, 32'd0);
    to_next();

    // Test 4: error response queued behind a slow network response
    net_req_ready_i = 1'b1;
    drive(1'b0, 32'h8000_1004, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    to_neg();
    check("t4_net_gnt", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    drive(1'b0, 32'h9000_0000, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    to_neg();
    check("t4_err_gnt", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    data_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("t4_err_waits", {31'd0, data_rvalid_o}, 32'd0);
      to_next();
    end
    net_resp_valid_i = 1'b1;
    net_resp_rdata_i = 32'hCAFE_F00D;
    to_neg();
    check("t4_net_first", {31'd0, data_err_o}, 32'd0);
    to_next();
    net_resp_valid_i = 1'b0;
    to_neg();
    check("t4_err_second", {31'd0, data_err_o}, 32'd1);
    to_next();

    // Test 5: third request stalls while two are outstanding
    drive(1'b0, 32'h0010_0000, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b0, rdata: 32'h0000_1111});
    to_neg();
    check("t5_gnt0", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    data_addr_i = 32'h0010_0008;
    exp_q.push_back('{err: 1'b0, rdata: 32'h0000_2222});
    to_neg();
    check("t5_gnt1", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    data_addr_i = 32'h0010_000C;
    for (int i = 0; i < 2; i++) begin
      to_neg();
      check("t5_full_gnt", {31'd0, data_gnt_o}, 32'd0);
      check("t5_full_valid", {31'd0, net_req_valid_o}, 32'd0);
      to_next();
    end
    net_resp_valid_i = 1'b1;
    net_resp_rdata_i = 32'h0000_1111;
    to_neg();
    check("t5_pop_no_gnt", {31'd0, data_gnt_o}, 32'd0);
    to_next();
    net_resp_valid_i = 1'b0;
    exp_q.push_back('{err: 1'b0, rdata: 32'h0000_3333});
    to_neg();
    check("t5_gnt2", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    data_req_i       = 1'b0;
    net_resp_valid_i = 1'b1;
    net_resp_rdata_i = 32'h0000_2222;
    to_neg();
    to_next();
    net_resp_rdata_i = 32'h0000_3333;
    to_neg();
    to_next();
    net_resp_valid_i = 1'b0;

    // Test 6: asynchronous reset with two outstanding, then normal traffic
    drive(1'b0, 32'h8000_2000, 4'hF, 32'h0);
    to_neg();
    check("t6_gnt0", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    data_addr_i = 32'h0010_0010;
    to_neg();
    check("t6_gnt1", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    #2;
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_resp_ready", {31'd0, net_resp_ready_o}, 32'd0);
    check("t6_rst_gnt", {31'd0, data_gnt_o}, 32'd0);
    check("t6_rst_req_valid", {31'd0, net_req_valid_o}, 32'd0);
    data_req_i = 1'b0;
    to_next();
    to_next();
    rst_ni = 1'b1;
    to_neg();
    check("t6_post_resp_ready", {31'd0, net_resp_ready_o}, 32'd0);
    check("t6_post_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    to_next();
    drive(1'b0, 32'h0010_0020, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b0, rdata: 32'h55AA_55AA});
    to_neg();
    check("t6_new_gnt0", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    data_addr_i = 32'h0010_0024;
    exp_q.push_back('{err: 1'b0, rdata: 32'h0F0F_0F0F});
    to_neg();
    check("t6_new_gnt1", {31'd0, data_gnt_o}, 32'd1);
    to_next();
    data_req_i       = 1'b0;
    net_resp_valid_i = 1'b1;
    net_resp_rdata_i = 32'h55AA_55AA;
    to_neg();
    to_next();
    net_resp_rdata_i = 32'h0F0F_0F0F;
    to_neg();
    to_next();
    net_resp_valid_i = 1'b0;

    to_neg();
    check("all_responses_seen", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_data_bridge.md
Name: ibex_data_bridge

Overview:
Adapter between the Ibex data port (req/gnt/rvalid protocol) and one host port of the L1 variable-latency interconnect (valid/ready request and response channels). It sits directly upstream of the interconnect, replacing the direct wiring of core data signals. It decodes addresses against the system map and forwards only mapped accesses. Unmapped accesses receive a local error response, kept in order with network responses.

Parameters:
DataWidth, 32, data and address width
MaxOutstanding, 2, maximum accepted-but-unanswered transactions (power of two, >=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid
data_we_i  in  1  write enable
data_be_i  in  DataWidth/8  byte enable
data_addr_i  in  DataWidth  byte address
data_wdata_i  in  DataWidth  write data
data_rdata_o  out  DataWidth  read data
data_err_o  out  1  bus error, qualified by data_rvalid_o
net_req_valid_o  out  1  request valid to interconnect
net_req_ready_i  in  1  interconnect accepts request
net_tgt_addr_o  out  DataWidth  target address (unmodified data_addr_i)
net_wen_o  out  1  write enable
net_be_o  out  DataWidth/8  byte enable
net_wdata_o  out  DataWidth  write data
net_resp_valid_i  in  1  response valid from interconnect
net_resp_ready_o  out  1  bridge accepts response
net_resp_rdata_i  in  DataWidth  response data

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset: order FIFO empty, outstanding count 0. All outputs are 0 during reset.
- Address decode is combinational. An address is mapped if it hits RAM (0x0010_0000, 64 KiB), GPIO (0x8000_0000, 4 KiB), UART (0x8000_1000, 4 KiB) or TIMER (0x8000_2000, 4 KiB). Hit test is (addr & MASK) == START.
- full = (count == MaxOutstanding).
- net_req_valid_o = data_req_i & mapped & ~full.
- net_tgt_addr_o, net_wen_o, net_be_o and net_wdata_o are combinational pass-throughs.
- data_gnt_o = data_req_i & ~full & (unmapped | net_req_ready_i).
- Issue is zero-latency: grant occurs in the same cycle as the request when the conditions hold. Combinational paths req->valid and ready->gnt are allowed.
- On each grant, one tag is pushed into the order FIFO: NET if mapped, ERR if unmapped. The tag becomes visible at the head no earlier than the next cycle, so rvalid is never in the same cycle as gnt.
- Response path is driven from the FIFO head, when the FIFO is non-empty:
  - Head ERR: data_rvalid_o=1, data_err_o=1, data_rdata_o=0, net_resp_ready_o=0.
  - Head NET: net_resp_ready_o=1, data_rvalid_o=net_resp_valid_i, data_err_o=0, data_rdata_o=net_resp_rdata_i.
- FIFO empty: data_rvalid_o=0, net_resp_ready_o=0, data_rdata_o=0.
- The FIFO pops when data_rvalid_o=1. The core always accepts rvalid, so there is no backpressure toward the core.
- The interconnect returns exactly one response per request, reads and writes alike.
- count increments on grant, decrements on pop, and is unchanged when both occur in the same cycle.
- No grant while full, even if a pop occurs in the same cycle (conservative).
- Response ordering: responses are returned strictly in grant order. An ERR behind a pending NET waits for that NET response.
- net_resp_valid_i while the head is ERR or the FIFO is empty: not consumed, because ready is low. An SVA flags the empty case as a protocol error.
- data_req_i withdrawn before grant is legal. Nothing is pushed.
- Reset mid-operation flushes all tags. Late network responses after reset see ready=0 and are the integrator's concern.
- Wrap-around: FIFO pointers are log2(MaxOutstanding)+1 bits wide. Full/empty are decided by MSB compare.

Decomposition:
- pinaipple_pkg holds:
  - address map localparams (*START, *SIZE, *MASK for RAM, GPIO, UART, TIMER);
  - resp_tag_e enum {TagNet, TagErr}.
- Sub-module resp_order_fifo: parameterised depth, 1-bit payload, push/pop/empty/full/head outputs.
- The bridge contains decode, handshake glue and the counter.

Test Plan:
1. Read 0x0010_0004, net_req_ready=1, response 0xDEADBEEF two cycles later -> gnt in cycle 0, rvalid=1 with rdata 0xDEADBEEF and err=0 in that response cycle.
2. Write 0x8000_0000, be=4'b0011, net_req_ready low for 3 cycles -> gnt only in the 4th cycle; net_wen_o=1; net_be_o=0011 throughout.
3. Read 0x4000_0000 (unmapped) -> gnt same cycle, net_req_valid_o stays 0, rvalid=1 err=1 rdata=0 next cycle.
4. Mapped read (network responds after 5 cycles) followed by an unmapped read -> second gnt is accepted. Responses come in order: NET data first, then err on the following cycle.
5. Three back-to-back mapped reads with MaxOutstanding=2 and responses withheld -> third gnt is held low until the first response pops.
6. Assert rst_ni low with 2 outstanding -> count=0, FIFO empty, net_resp_ready_o=0. A subsequent read completes normally.
